// File: rtl/axis_capture_arbiter.sv
// axis_capture_arbiter
// Packet-level round-robin arbiter that merges NUM_SRC AXI4-Stream capture sources
// onto one output stream. Each granted packet may be prefixed by a header beat that
// carries {sequence number, source id}. A watchdog truncates a packet whose source goes
// quiet mid-packet, emits a flagged terminator beat, and then drains the remainder of
// that packet from the source.

module axis_capture_arbiter #(
  parameter int NUM_SRC       = 2,
  parameter int DATA_WIDTH    = 64,
  parameter int HEADER_EN     = 1,
  parameter int STALL_TIMEOUT = 256
) (
  input  logic                            aclk,
  input  logic                            areset,
  input  logic                            enable,
  input  logic [NUM_SRC*DATA_WIDTH-1:0]   s_tdata,
  input  logic [NUM_SRC-1:0]              s_tvalid,
  input  logic [NUM_SRC-1:0]              s_tlast,
  output logic [NUM_SRC-1:0]              s_tready,
  output logic [DATA_WIDTH-1:0]           m_tdata,
  output logic                            m_tvalid,
  output logic                            m_tlast,
  output logic                            m_tuser,
  input  logic                            m_tready,
  output logic [NUM_SRC-1:0]              grant,
  output logic                            busy,
  output logic [15:0]                     timeout_cnt
);

  localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int SW = (STALL_TIMEOUT > 1) ? $clog2(STALL_TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    DATA = 3'd2,
    TERM = 3'd3,
    DROP = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [IW-1:0]           gidx_q, gidx_d;
  logic [IW-1:0]           last_q, last_d;
  logic [NUM_SRC-1:0]      grant_q, grant_d;
  logic [SW-1:0]           stall_q, stall_d;
  logic [15:0]             tcnt_q, tcnt_d;
  logic [7:0]              seq_q [NUM_SRC];
  logic                    seq_inc;

  logic                    pick_vld;
  logic [IW-1:0]           pick_idx;
  logic [IW-1:0]           cand;
  logic [DATA_WIDTH-1:0]   src_data;
  logic [DATA_WIDTH-1:0]   hdr_data;

  // Circular increment of a source index, wrapping NUM_SRC-1 back to 0.
  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx);
    if (idx == IW'(NUM_SRC - 1)) begin
      return '0;
    end
    return idx + IW'(1);
  endfunction

  assign src_data = s_tdata[int'(gidx_q)*DATA_WIDTH +: DATA_WIDTH];

  // Header beat: {zero padding, sequence number of owner, owner id}.
  always_comb begin
    hdr_data       = '0;
    hdr_data[15:8] = seq_q[gidx_q];
    hdr_data[7:0]  = 8'(gidx_q);
  end

  // Round-robin search: first valid source starting just after the last owner.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = last_q;
    for (int i = 0; i < NUM_SRC; i++) begin
      cand = next_idx(cand);
      if (!pick_vld && s_tvalid[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  // Next-state and output decode; stream outputs are combinational from the state.
  always_comb begin
    state_d  = state_q;
    gidx_d   = gidx_q;
    last_d   = last_q;
    grant_d  = grant_q;
    stall_d  = stall_q;
    tcnt_d   = tcnt_q;
    seq_inc  = 1'b0;
    s_tready = '0;
    m_tvalid = 1'b0;
    m_tlast  = 1'b0;
    m_tuser  = 1'b0;
    m_tdata  = '0;
    case (state_q)
      IDLE: begin
        if (enable && pick_vld) begin
          gidx_d  = pick_idx;
          last_d  = pick_idx;
          grant_d = NUM_SRC'(1) << pick_idx;
          stall_d = '0;
          state_d = (HEADER_EN != 0) ? HDR : DATA;
        end
      end
      HDR: begin
        m_tvalid = 1'b1;
        m_tdata  = hdr_data;
        if (m_tready) begin
          state_d = DATA;
        end
      end
      DATA: begin
        m_tvalid         = s_tvalid[gidx_q];
        m_tdata          = src_data;
        m_tlast          = s_tlast[gidx_q];
        s_tready[gidx_q] = m_tready;
        if (s_tvalid[gidx_q]) begin
          // A presented beat proves the source is alive, even under backpressure.
          stall_d = '0;
          if (m_tready && s_tlast[gidx_q]) begin
            seq_inc = 1'b1;
            grant_d = '0;
            state_d = IDLE;
          end
        end else if (STALL_TIMEOUT > 0) begin
          if (stall_q == SW'(STALL_TIMEOUT - 1)) begin
            stall_d = '0;
            state_d = TERM;
          end else begin
            stall_d = stall_q + SW'(1);
          end
        end
      end
      TERM: begin
        m_tvalid = 1'b1;
        m_tlast  = 1'b1;
        m_tuser  = 1'b1;
        if (m_tready) begin
          seq_inc = 1'b1;
          if (tcnt_q != 16'hFFFF) begin
            tcnt_d = tcnt_q + 16'd1;
          end
          state_d = DROP;
        end
      end
      DROP: begin
        // Swallow the rest of the truncated packet so the source can resynchronise.
        s_tready[gidx_q] = 1'b1;
        if (s_tvalid[gidx_q] && s_tlast[gidx_q]) begin
          grant_d = '0;
          state_d = IDLE;
        end
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Control state registers.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= IDLE;
      gidx_q  <= '0;
      last_q  <= IW'(NUM_SRC - 1);
      grant_q <= '0;
      stall_q <= '0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      gidx_q  <= gidx_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      stall_q <= stall_d;
      tcnt_q  <= tcnt_d;
    end
  end

  // Per-source packet sequence numbers, bumped on completion or truncation.
  always_ff @(posedge aclk) begin
    if (areset) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        seq_q[i] <= '0;
      end
    end else if (seq_inc) begin
      seq_q[gidx_q] <= seq_q[gidx_q] + 8'd1;
    end
  end

  assign grant       = grant_q;
  assign busy        = (state_q != IDLE);
  assign timeout_cnt = tcnt_q;

endmodule

// File: tb/tb_axis_capture_arbiter.sv
// Testbench for axis_capture_arbiter: scoreboard of expected output beats plus
// per-scenario inline checks of control outputs and timing.

module tb_axis_capture_arbiter;

  localparam int NS = 2;
  localparam int DW = 32;
  localparam int TO = 16;

  logic              aclk;
  logic              areset;
  logic              enable;
  logic [NS*DW-1:0]  s_tdata;
  logic [NS-1:0]     s_tvalid;
  logic [NS-1:0]     s_tlast;
  logic [NS-1:0]     s_tready;
  logic [DW-1:0]     m_tdata;
  logic              m_tvalid;
  logic              m_tlast;
  logic              m_tuser;
  logic              m_tready;
  logic [NS-1:0]     grant;
  logic              busy;
  logic [15:0]       timeout_cnt;

  logic              vld_src [NS];
  logic              lst_src [NS];
  logic [DW-1:0]     dat_src [NS];

  for (genvar g = 0; g < NS; g++) begin : g_src
    assign s_tvalid[g]           = vld_src[g];
    assign s_tlast[g]            = lst_src[g];
    assign s_tdata[g*DW +: DW]   = dat_src[g];
  end

  int nvec;
  int nerr;
  logic [DW+1:0] exp_q[$];
  logic [DW+1:0] mon_e;

  axis_capture_arbiter #(
    .NUM_SRC      (NS),
    .DATA_WIDTH   (DW),
    .HEADER_EN    (1),
    .STALL_TIMEOUT(TO)
  ) dut (
    .aclk       (aclk),
    .areset     (areset),
    .enable     (enable),
    .s_tdata    (s_tdata),
    .s_tvalid   (s_tvalid),
    .s_tlast    (s_tlast),
    .s_tready   (s_tready),
    .m_tdata    (m_tdata),
    .m_tvalid   (m_tvalid),
    .m_tlast    (m_tlast),
    .m_tuser    (m_tuser),
    .m_tready   (m_tready),
    .grant      (grant),
    .busy       (busy),
    .timeout_cnt(timeout_cnt)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #2000000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "global timeout");
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Scoreboard consumer: every accepted output beat must match the head of the queue.
  task automatic run_monitor();
    forever begin
      @(negedge aclk);
      if (!areset && m_tvalid && m_tready) begin
        nvec++;
        if (exp_q.size() == 0) begin
          nerr++;
          $display("FAIL beat_unexpected got data=%h last=%b user=%b required no beat",
                   m_tdata, m_tlast, m_tuser);
        end else begin
          mon_e = exp_q.pop_front();
          if ({m_tdata, m_tlast, m_tuser} !== mon_e) begin
            nerr++;
            $display("FAIL beat got data=%h last=%b user=%b required data=%h last=%b user=%b",
                     m_tdata, m_tlast, m_tuser, mon_e[DW+1:2], mon_e[1], mon_e[0]);
          end
        end
      end
    end
  endtask

  task automatic push_hdr(input logic [7:0] seq, input logic [7:0] id);
    logic [DW-1:0] h;
    h       = '0;
    h[15:8] = seq;
    h[7:0]  = id;
    exp_q.push_back({h, 1'b0, 1'b0});
  endtask

  task automatic push_beats(input logic [DW-1:0] base, input int n, input bit has_last);
    for (int b = 0; b < n; b++) begin
      exp_q.push_back({base + DW'(b), (has_last && (b == n - 1)), 1'b0});
    end
  endtask

  task automatic push_term();
    exp_q.push_back({{DW{1'b0}}, 1'b1, 1'b1});
  endtask

  // Source model: presents n consecutive beats base, base+1, ... honouring s_tready.
  task automatic send_pkt(input int src, input int n, input logic [DW-1:0] base,
                          input bit has_last);
    bit ok;
    for (int b = 0; b < n; b++) begin
      vld_src[src] = 1'b1;
      dat_src[src] = base + DW'(b);
      lst_src[src] = has_last && (b == n - 1);
      ok = 1'b0;
      for (int c = 0; c < 300 && !ok; c++) begin
        @(negedge aclk);
        ok = s_tready[src];
        @(posedge aclk);
        #1;
      end
      if (!ok) begin
        nvec++;
        nerr++;
        $display("FAIL src%0d_handshake got no s_tready in 300 cycles required handshake", src);
        vld_src[src] = 1'b0;
        lst_src[src] = 1'b0;
        return;
      end
    end
    vld_src[src] = 1'b0;
    lst_src[src] = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int c = 0; c < 200 && exp_q.size() != 0; c++) begin
      @(negedge aclk);
    end
    nvec++;
    if (exp_q.size() != 0) begin
      nerr++;
      $display("FAIL %s_drain got %0d beats outstanding required 0", name, exp_q.size());
    end
  endtask

  task automatic do_reset();
    for (int i = 0; i < NS; i++) begin
      vld_src[i] = 1'b0;
      lst_src[i] = 1'b0;
      dat_src[i] = '0;
    end
    exp_q.delete();
    areset = 1'b1;
    tick();
    tick();
    areset = 1'b0;
  endtask

  task automatic test_reset();
    enable   = 1'b1;
    m_tready = 1'b1;
    do_reset();
    areset = 1'b1;
    @(negedge aclk);
    nvec++;
    if ({m_tvalid, m_tlast, m_tuser, busy} !== 4'b0000) begin
      nerr++;
      $display("FAIL reset_flags got vld/last/user/busy=%b required 0000",
               {m_tvalid, m_tlast, m_tuser, busy});
    end
    nvec++;
    if (grant !== 2'b00 || s_tready !== 2'b00) begin
      nerr++;
      $display("FAIL reset_grant got grant=%b s_tready=%b required 00 00", grant, s_tready);
    end
    nvec++;
    if (m_tdata !== 32'h0 || timeout_cnt !== 16'h0) begin
      nerr++;
      $display("FAIL reset_data got m_tdata=%h timeout_cnt=%h required 0 0", m_tdata, timeout_cnt);
    end
    @(posedge aclk);
    #1;
    areset = 1'b0;
  endtask

  task automatic test_single_packet();
    do_reset();
    push_hdr(8'd0, 8'd0);
    push_beats(32'hA000_0000, 3, 1'b1);
    fork
      send_pkt(0, 3, 32'hA000_0000, 1'b1);
      begin
        @(negedge aclk);
        nvec++;
        if ({m_tvalid, grant} !== 3'b000) begin
          nerr++;
          $display("FAIL lat_idle got vld=%b grant=%b required 0 00", m_tvalid, grant);
        end
        @(negedge aclk);
        nvec++;
        if ({m_tvalid, grant, busy, m_tdata} !== {1'b1, 2'b01, 1'b1, 32'h0}) begin
          nerr++;
          $display("FAIL lat_hdr got vld=%b grant=%b busy=%b data=%h required 1 01 1 0",
                   m_tvalid, grant, busy, m_tdata);
        end
        @(negedge aclk);
        nvec++;
        if ({m_tvalid, m_tdata} !== {1'b1, 32'hA000_0000}) begin
          nerr++;
          $display("FAIL lat_data got vld=%b data=%h required 1 a0000000", m_tvalid, m_tdata);
        end
      end
    join
    wait_drain("single");
    // One-beat packet from the same source shows the incremented sequence number.
    push_hdr(8'd1, 8'd0);
    push_beats(32'hB000_0000, 1, 1'b1);
    send_pkt(0, 1, 32'hB000_0000, 1'b1);
    @(negedge aclk);
    nvec++;
    if ({busy, grant} !== 3'b000) begin
      nerr++;
      $display("FAIL onebeat_idle got busy=%b grant=%b required 0 00", busy, grant);
    end
    wait_drain("onebeat");
  endtask

  task automatic test_round_robin();
    do_reset();
    push_hdr(8'd0, 8'd0); push_beats(32'h1000_0000, 2, 1'b1);
    push_hdr(8'd0, 8'd1); push_beats(32'h2000_0000, 2, 1'b1);
    push_hdr(8'd1, 8'd0); push_beats(32'h1000_0010, 2, 1'b1);
    push_hdr(8'd1, 8'd1); push_beats(32'h2000_0010, 2, 1'b1);
    fork
      begin
        send_pkt(0, 2, 32'h1000_0000, 1'b1);
        send_pkt(0, 2, 32'h1000_0010, 1'b1);
      end
      begin
        send_pkt(1, 2, 32'h2000_0000, 1'b1);
        send_pkt(1, 2, 32'h2000_0010, 1'b1);
      end
    join
    wait_drain("rr");
  endtask

  task automatic test_backpressure();
    bit done;
    do_reset();
    done = 1'b0;
    push_hdr(8'd0, 8'd0);
    push_beats(32'hC000_0000, 16, 1'b1);
    fork
      begin
        send_pkt(0, 16, 32'hC000_0000, 1'b1);
        done = 1'b1;
      end
      begin
        while (!done) begin
          m_tready = 1'b0;
          repeat (5) tick();
          m_tready = 1'b1;
          repeat (5) tick();
        end
      end
    join
    m_tready = 1'b1;
    wait_drain("bp");
    nvec++;
    if (timeout_cnt !== 16'd0) begin
      nerr++;
      $display("FAIL bp_timeout_cnt got %0d required 0", timeout_cnt);
    end
  endtask

  task automatic test_watchdog();
    int n;
    bit found;
    do_reset();
    push_hdr(8'd0, 8'd1);
    push_beats(32'hD000_0000, 2, 1'b0);
    push_term();
    send_pkt(1, 2, 32'hD000_0000, 1'b0);
    found = 1'b0;
    n = 0;
    for (int k = 1; k <= 40 && !found; k++) begin
      @(negedge aclk);
      if (m_tuser) begin
        found = 1'b1;
        n = k;
      end
    end
    nvec++;
    if (n != TO + 1) begin
      nerr++;
      $display("FAIL term_latency got negedge %0d required %0d", n, TO + 1);
    end
    @(posedge aclk);
    #1;
    repeat (3) tick();
    send_pkt(1, 4, 32'hD000_0008, 1'b1);
    @(negedge aclk);
    nvec++;
    if ({timeout_cnt, busy} !== {16'd1, 1'b0}) begin
      nerr++;
      $display("FAIL wd_count got timeout_cnt=%0d busy=%b required 1 0", timeout_cnt, busy);
    end
    wait_drain("wd");
    push_hdr(8'd1, 8'd1);
    push_beats(32'hDF00_0000, 1, 1'b1);
    send_pkt(1, 1, 32'hDF00_0000, 1'b1);
    wait_drain("wd_next");
  endtask

  task automatic test_enable_hold();
    bit bad;
    do_reset();
    push_hdr(8'd0, 8'd0); push_beats(32'hE000_0000, 4, 1'b1);
    push_hdr(8'd0, 8'd1); push_beats(32'hF000_0000, 2, 1'b1);
    fork
      send_pkt(0, 4, 32'hE000_0000, 1'b1);
      begin
        repeat (3) tick();
        enable = 1'b0;
      end
    join
    bad = 1'b0;
    fork
      send_pkt(1, 2, 32'hF000_0000, 1'b1);
      begin
        repeat (5) begin
          @(negedge aclk);
          if (grant !== 2'b00 || busy !== 1'b0) bad = 1'b1;
        end
        nvec++;
        if (bad) begin
          nerr++;
          $display("FAIL en_hold got grant=%b busy=%b required 00 0 while disabled", grant, busy);
        end
        @(posedge aclk);
        #1;
        enable = 1'b1;
        @(negedge aclk);
        nvec++;
        if (grant !== 2'b00) begin
          nerr++;
          $display("FAIL en_same_cycle got grant=%b required 00", grant);
        end
        @(negedge aclk);
        nvec++;
        if (grant !== 2'b10) begin
          nerr++;
          $display("FAIL en_next_cycle got grant=%b required 10", grant);
        end
      end
    join
    wait_drain("en");
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    push_hdr(8'd0, 8'd1);
    push_beats(32'h5000_0000, 1, 1'b1);
    send_pkt(1, 1, 32'h5000_0000, 1'b1);
    wait_drain("mid_pre");
    push_hdr(8'd1, 8'd1);
    push_beats(32'h6000_0000, 1, 1'b0);
    vld_src[1] = 1'b1;
    dat_src[1] = 32'h6000_0000;
    lst_src[1] = 1'b0;
    tick();
    tick();
    tick();
    dat_src[1] = 32'h6000_0001;
    areset = 1'b1;
    tick();
    areset = 1'b0;
    vld_src[1] = 1'b0;
    @(negedge aclk);
    nvec++;
    if ({m_tvalid, s_tready, grant, busy} !== 6'b0) begin
      nerr++;
      $display("FAIL mid_rst got vld=%b s_tready=%b grant=%b busy=%b required 0 00 00 0",
               m_tvalid, s_tready, grant, busy);
    end
    nvec++;
    if (exp_q.size() != 0) begin
      nerr++;
      $display("FAIL mid_rst_beats got %0d outstanding required 0", exp_q.size());
    end
    exp_q.delete();
    push_hdr(8'd0, 8'd1);
    push_beats(32'h7000_0000, 1, 1'b1);
    send_pkt(1, 1, 32'h7000_0000, 1'b1);
    wait_drain("mid_post");
  endtask

  initial begin
    nvec     = 0;
    nerr     = 0;
    areset   = 1'b1;
    enable   = 1'b1;
    m_tready = 1'b1;
    for (int i = 0; i < NS; i++) begin
      vld_src[i] = 1'b0;
      lst_src[i] = 1'b0;
      dat_src[i] = '0;
    end
    fork
      run_monitor();
    join_none
    test_reset();
    test_single_packet();
    test_round_robin();
    test_backpressure();
    test_watchdog();
    test_enable_hold();
    test_reset_mid_packet();
    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
